ov7670_frame_capture: RTL and testbench

//  Upstream of the dual-port M9K frame buffer. Samples the OV7670 camera bus (VSYNC, HREF, D[7:0])
//  on the camera pixel clock and pairs each two bytes into one RGB565 pixel.

---
 rtl/ov7670_frame_capture.sv | 155 +++++++++++++++
 tb/tb_ov7670_frame_capture.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_frame_capture.sv
// OV7670 byte-pair capture: RGB565 -> RGB332 writes into a clipped frame buffer.
// Reports line/frame completion and unpaired-byte errors.
module ov7670_frame_capture #(
  parameter int SCREEN_WIDTH  = 176,
  parameter int SCREEN_HEIGHT = 144,
  parameter int ADDR_W        = 15
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CAM_VSYNC,
  input  logic              CAM_HREF,
  input  logic [7:0]        CAM_DATA,
  output logic              W_EN,
  output logic [ADDR_W-1:0] W_ADDR,
  output logic [7:0]        W_DATA,
  output logic              LINE_DONE,
  output logic              FRAME_DONE,
  output logic [7:0]        FRAME_LINES,
  output logic              ODD_BYTE_ERR
);

  localparam int XW = $clog2(SCREEN_WIDTH + 1);
  localparam int YW = $clog2(SCREEN_HEIGHT + 1);
  localparam logic [XW-1:0] X_LIM = XW'(SCREEN_WIDTH);
  localparam logic [YW-1:0] Y_LIM = YW'(SCREEN_HEIGHT);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(SCREEN_WIDTH);

  typedef enum logic [2:0] {
    WAIT_VS,
    IN_VS,
    LINE_IDLE,
    BYTE_HI,
    BYTE_LO
  } state_t;

  state_t state, state_n;

  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [ADDR_W-1:0] line_base;
  logic [7:0]        line_cnt;
  logic [7:0]        hi_byte;

  logic clear, latch_hi, pix, line_end, frame_end, odd;

  always_comb begin
    state_n   = state;
    clear     = 1'b0;
    latch_hi  = 1'b0;
    pix       = 1'b0;
    line_end  = 1'b0;
    frame_end = 1'b0;
    odd       = 1'b0;
    unique case (state)
      WAIT_VS: begin
        if (CAM_VSYNC) state_n = IN_VS;
      end
      IN_VS: begin
        if (!CAM_VSYNC) begin
          clear   = 1'b1;
          state_n = LINE_IDLE;
        end
      end
      LINE_IDLE: begin
        if (CAM_VSYNC) begin
          frame_end = 1'b1;
          state_n   = IN_VS;
        end else if (CAM_HREF) begin
          latch_hi = 1'b1;
          state_n  = BYTE_LO;
        end
      end
      BYTE_HI: begin
        if (CAM_VSYNC) begin
          frame_end = 1'b1;
          state_n   = IN_VS;
        end else if (CAM_HREF) begin
          latch_hi = 1'b1;
          state_n  = BYTE_LO;
        end else begin
          line_end = 1'b1;
          state_n  = LINE_IDLE;
        end
      end
      BYTE_LO: begin
        if (CAM_VSYNC) begin
          frame_end = 1'b1;
          state_n   = IN_VS;
        end else if (CAM_HREF) begin
          pix     = 1'b1;
          state_n = BYTE_HI;
        end else begin
          odd      = 1'b1;
          line_end = 1'b1;
          state_n  = LINE_IDLE;
        end
      end
      default: state_n = WAIT_VS;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= WAIT_VS;
      x            <= '0;
      y            <= '0;
      line_base    <= '0;
      line_cnt     <= '0;
      hi_byte      <= '0;
      W_EN         <= 1'b0;
      W_ADDR       <= '0;
      W_DATA       <= '0;
      LINE_DONE    <= 1'b0;
      FRAME_DONE   <= 1'b0;
      FRAME_LINES  <= '0;
      ODD_BYTE_ERR <= 1'b0;
    end else begin
      state      <= state_n;
      W_EN       <= 1'b0;
      LINE_DONE  <= 1'b0;
      FRAME_DONE <= 1'b0;
      if (clear) begin
        x         <= '0;
        y         <= '0;
        line_base <= '0;
        line_cnt  <= '0;
      end
      if (latch_hi) hi_byte <= CAM_DATA;
      if (pix) begin
        if (x < X_LIM && y < Y_LIM) begin
          W_EN   <= 1'b1;
          W_ADDR <= line_base + ADDR_W'(x);
          W_DATA <= {hi_byte[7:5], hi_byte[2:0], CAM_DATA[4:3]};
        end
        if (x != X_LIM) x <= x + XW'(1);
      end
      if (line_end) begin
        LINE_DONE <= 1'b1;
        x         <= '0;
        // line_base stops advancing once y saturates, bounding W_ADDR
        if (y < Y_LIM) begin
          y         <= y + YW'(1);
          line_base <= line_base + STRIDE;
        end
        if (line_cnt != 8'hFF) line_cnt <= line_cnt + 8'd1;
      end
      if (odd) ODD_BYTE_ERR <= 1'b1;
      if (frame_end && line_cnt != 8'd0) begin
        FRAME_DONE  <= 1'b1;
        FRAME_LINES <= line_cnt;
      end
    end
  end

endmodule

// File: tb/tb_ov7670_frame_capture.sv
// Directed bench for ov7670_frame_capture.
// Inputs change on negedge; outputs checked on the following negedge.
module tb_ov7670_frame_capture;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        CAM_VSYNC, CAM_HREF;
  logic [7:0]  CAM_DATA;
  logic        W_EN;
  logic [14:0] W_ADDR;
  logic [7:0]  W_DATA;
  logic        LINE_DONE, FRAME_DONE;
  logic [7:0]  FRAME_LINES;
  logic        ODD_BYTE_ERR;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_cnt = 0;
  int ld_cnt = 0;
  int max_addr = -1;
  int wr0, ld0;

  ov7670_frame_capture dut (
    .CLK(CLK), .RESET(RESET),
    .CAM_VSYNC(CAM_VSYNC), .CAM_HREF(CAM_HREF),
    .CAM_DATA(CAM_DATA),
    .W_EN(W_EN), .W_ADDR(W_ADDR), .W_DATA(W_DATA),
    .LINE_DONE(LINE_DONE), .FRAME_DONE(FRAME_DONE),
    .FRAME_LINES(FRAME_LINES), .ODD_BYTE_ERR(ODD_BYTE_ERR)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    #2;
    if (W_EN) begin
      wr_cnt++;
      if (int'(W_ADDR) > max_addr) max_addr = int'(W_ADDR);
    end
    if (LINE_DONE) ld_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic vs, input logic hr,
                       input logic [7:0] d);
    CAM_VSYNC = vs;
    CAM_HREF  = hr;
    CAM_DATA  = d;
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic send_pixel(input logic [7:0] h,
                            input logic [7:0] l);
    drive(1'b0, 1'b1, h);
    tick();
    drive(1'b0, 1'b1, l);
    tick();
  endtask

  task automatic end_line();
    drive(1'b0, 1'b0, 8'h00);
    tick();
  endtask

  task automatic vsync_pulse();
    drive(1'b1, 1'b0, 8'h00);
    tick();
    tick();
    drive(1'b0, 1'b0, 8'h00);
    tick();
    tick();
  endtask

  initial begin
    RESET = 1'b1;
    drive(1'b0, 1'b0, 8'h00);
    tick();
    tick();
    chk("rst_wen", 32'(W_EN), 0);
    chk("rst_addr", 32'(W_ADDR), 0);
    chk("rst_data", 32'(W_DATA), 0);
    chk("rst_ld", 32'(LINE_DONE), 0);
    chk("rst_fd", 32'(FRAME_DONE), 0);
    chk("rst_fl", 32'(FRAME_LINES), 0);
    chk("rst_odd", 32'(ODD_BYTE_ERR), 0);
    RESET = 1'b0;

    // 1: two lines of two pixels
    vsync_pulse();
    drive(1'b0, 1'b1, 8'hF8);
    tick();
    chk("t1_hi_wen", 32'(W_EN), 0);
    drive(1'b0, 1'b1, 8'h00);
    tick();
    chk("t1_p0_wen", 32'(W_EN), 1);
    chk("t1_p0_addr", 32'(W_ADDR), 0);
    chk("t1_p0_data", 32'(W_DATA), 32'hE0);
    send_pixel(8'h07, 8'hE0);
    chk("t1_p1_addr", 32'(W_ADDR), 1);
    chk("t1_p1_data", 32'(W_DATA), 32'h1C);
    end_line();
    chk("t1_ld", 32'(LINE_DONE), 1);
    chk("t1_ld_wen", 32'(W_EN), 0);
    chk("t1_hold", 32'(W_ADDR), 1);
    tick();
    chk("t1_ld_off", 32'(LINE_DONE), 0);
    send_pixel(8'hF8, 8'h00);
    chk("t1_p2_addr", 32'(W_ADDR), 176);
    chk("t1_p2_data", 32'(W_DATA), 32'hE0);
    send_pixel(8'h07, 8'hE0);
    chk("t1_p3_addr", 32'(W_ADDR), 177);
    chk("t1_p3_wen", 32'(W_EN), 1);
    end_line();
    drive(1'b1, 1'b0, 8'h00);
    tick();
    chk("t1_fd", 32'(FRAME_DONE), 1);
    chk("t1_fl", 32'(FRAME_LINES), 2);
    tick();
    chk("t1_fd_off", 32'(FRAME_DONE), 0);
    drive(1'b0, 1'b0, 8'h00);
    tick();
    tick();

    // 2: 200-pixel line clipped to 176
    wr0 = wr_cnt;
    for (int i = 0; i < 200; i++) send_pixel(8'(i), 8'h18);
    end_line();
    tick();
    chk("t2_writes", 32'(wr_cnt - wr0), 176);
    chk("t2_last", 32'(W_ADDR), 175);
    send_pixel(8'h00, 8'h00);
    chk("t2_next", 32'(W_ADDR), 176);
    end_line();
    drive(1'b1, 1'b0, 8'h00);
    tick();
    chk("t2_fl", 32'(FRAME_LINES), 2);
    drive(1'b0, 1'b0, 8'h00);
    tick();
    tick();

    // 3: 150 lines, last stored line is 143
    wr0 = wr_cnt;
    ld0 = ld_cnt;
    for (int ln = 0; ln < 150; ln++) begin
      for (int p = 0; p < ((ln >= 143) ? 176 : 1); p++)
        send_pixel(8'hFF, 8'hFF);
      end_line();
    end
    tick();
    chk("t3_writes", 32'(wr_cnt - wr0), 319);
    chk("t3_max", 32'(max_addr), 25343);
    chk("t3_lines", 32'(ld_cnt - ld0), 150);
    drive(1'b1, 1'b0, 8'h00);
    tick();
    chk("t3_fd", 32'(FRAME_DONE), 1);
    chk("t3_fl", 32'(FRAME_LINES), 150);
    drive(1'b0, 1'b0, 8'h00);
    tick();
    tick();

    // 4: three bytes then HREF drops
    wr0 = wr_cnt;
    send_pixel(8'hAA, 8'h55);
    chk("t4_data", 32'(W_DATA), 32'hAA);
    drive(1'b0, 1'b1, 8'hFF);
    tick();
    end_line();
    chk("t4_ld", 32'(LINE_DONE), 1);
    chk("t4_odd", 32'(ODD_BYTE_ERR), 1);
    tick();
    chk("t4_writes", 32'(wr_cnt - wr0), 1);
    drive(1'b1, 1'b0, 8'h00);
    tick();
    chk("t4_fl", 32'(FRAME_LINES), 1);
    drive(1'b0, 1'b0, 8'h00);
    tick();
    tick();
    send_pixel(8'h12, 8'h34);
    end_line();
    chk("t4_sticky", 32'(ODD_BYTE_ERR), 1);

    // 5: bus activity before the first VSYNC
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("t5_odd_clr", 32'(ODD_BYTE_ERR), 0);
    wr0 = wr_cnt;
    ld0 = ld_cnt;
    for (int i = 0; i < 5; i++) begin
      send_pixel(8'hF8, 8'h00);
      end_line();
    end
    tick();
    chk("t5_nowr", 32'(wr_cnt - wr0), 0);
    chk("t5_nold", 32'(ld_cnt - ld0), 0);
    drive(1'b1, 1'b1, 8'hF8);
    tick();
    drive(1'b1, 1'b1, 8'h00);
    tick();
    chk("t5_vs_wen", 32'(W_EN), 0);
    drive(1'b0, 1'b0, 8'h00);
    tick();
    tick();
    send_pixel(8'hF8, 8'h00);
    chk("t5_wen", 32'(W_EN), 1);
    chk("t5_addr", 32'(W_ADDR), 0);

    // 6: reset mid-line
    send_pixel(8'h07, 8'hE0);
    send_pixel(8'h07, 8'hE0);
    chk("t6_pre", 32'(W_ADDR), 2);
    drive(1'b0, 1'b1, 8'hF8);
    tick();
    RESET = 1'b1;
    drive(1'b0, 1'b1, 8'h00);
    tick();
    chk("t6_wen", 32'(W_EN), 0);
    chk("t6_addr", 32'(W_ADDR), 0);
    RESET = 1'b0;
    wr0 = wr_cnt;
    for (int i = 0; i < 3; i++) send_pixel(8'hF8, 8'h00);
    end_line();
    tick();
    chk("t6_nowr", 32'(wr_cnt - wr0), 0);
    vsync_pulse();
    send_pixel(8'h07, 8'hE0);
    chk("t6_resume_en", 32'(W_EN), 1);
    chk("t6_resume", 32'(W_ADDR), 0);
    chk("t6_data", 32'(W_DATA), 32'h1C);
    end_line();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
